// File: rtl/serial_add_seq.sv
// serial_add_seq
// Bit-serial add/subtract sequencer. A single 1-bit full-adder cell is fed one
// operand bit per cycle, LSB first, with the carry kept in a flip-flop between
// bits. It produces a WIDTH-bit sum or difference plus carry, overflow and zero
// flags.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   op_a, op_b, sub       operands and operation (sub=1: a + ~b + 1)
//   abort                 synchronous cancel, highest priority
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   result                WIDTH-bit sum or difference
//   carry_out             final carry (for sub, 1 = no borrow)
//   overflow              signed overflow
//   zero                  result == 0
//   busy                  sequencer is not idle
module serial_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_r_q, sh_r_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic fa_a;
    logic fa_b;
    logic fa_sum;
    logic fa_cout;

    // The single full-adder cell shared by every bit position.
    assign fa_a    = sh_a_q[0];
    assign fa_b    = sh_b_q[0];
    assign fa_sum  = fa_a ^ fa_b ^ cy_q;
    assign fa_cout = (fa_a & fa_b) | (cy_q & (fa_a ^ fa_b));

    always_comb begin
        state_d    = state_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
        sh_r_d     = sh_r_q;
        cy_d       = cy_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        case (state_q)
            IDLE: begin
                // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
                if (!abort && in_valid) begin
                    sh_a_d  = op_a;
                    sh_b_d  = sub ? ~op_b : op_b;
                    cy_d    = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
                    sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
                    sh_r_d = {fa_sum, sh_r_q[WIDTH-1:1]};
                    cy_d   = fa_cout;
                    cnt_d  = cnt_q + CW'(1);
                    // On the MSB, cy_q is the carry into that bit, so overflow is
                    // taken directly from it without a separate capture register.
                    if (cnt_q == LAST_BIT) begin
                        result_d   = sh_r_d;
                        carry_d    = fa_cout;
                        overflow_d = cy_q ^ fa_cout;
                        zero_d     = (sh_r_d == '0);
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_a_q     <= '0;
            sh_b_q     <= '0;
            sh_r_q     <= '0;
            cy_q       <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_a_q     <= sh_a_d;
            sh_b_q     <= sh_b_d;
            sh_r_q     <= sh_r_d;
            cy_q       <= cy_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } expect_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    vec_t vecs[8];

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic: modulo result, unsigned
    // no-borrow compare for subtraction, and signed range test for overflow.
    function automatic expect_t refModel(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
        expect_t     e;
        longint      sa;
        longint      sb;
        longint      sr;
        logic [32:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            e.r = a - b;
            e.c = (a >= b);
            sr  = sa - sb;
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            e.r  = wide[31:0];
            e.c  = wide[32];
            sr   = sa + sb;
        end
        e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    // Single comparison point: every check funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one request at a negedge and hold it through the accepting edge.
    task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic s);
        int waitCycles;
        waitCycles = 0;
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("in_ready_before_start", 32'(in_ready), 32'd1);
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        sub      = $urandom_range(0, 1);
    endtask

    // Count edges from acceptance (E0 = 1) until out_valid appears.
    task automatic waitDone(input string tag);
        int edges;
        edges = 1;
        while (!out_valid && edges < WIDTH + 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'(WIDTH + 1));
    endtask

    task automatic checkResult(input string tag, input expect_t e);
        checkOutput({tag, "_result"}, result, e.r);
        checkOutput({tag, "_carry"}, 32'(carry_out), 32'(e.c));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(e.v));
        checkOutput({tag, "_zero"}, 32'(zero), 32'(e.z));
    endtask

    task automatic popResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_idle_after_pop"}, 32'(in_ready), 32'd1);
    endtask

    // Full transaction: request, wait, compare against the given expectation, pop.
    task automatic applyStimulus(input string tag, input logic [31:0] a,
                                 input logic [31:0] b, input logic s, input expect_t e);
        startOp(a, b, s);
        waitDone(tag);
        checkResult(tag, e);
        popResult(tag);
    endtask

    initial begin
        expect_t e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        sawValid;

        vecs[0] = '{32'd5,        32'd3,        1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'd7,        32'd7,        1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'd0,        32'd0,        1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, including the carry/overflow/zero boundaries.
        for (int i = 0; i < 8; i++) begin
            e = '{vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z};
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, e);
        end

        // Abort in IDLE blocks the handshake.
        in_valid = 1'b1;
        abort    = 1'b1;
        op_a     = 32'd1;
        op_b     = 32'd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        checkOutput("idle_abort_busy", 32'(busy), 32'd0);

        // Backpressure: hold DONE for 10 cycles, then pop with a request already waiting.
        e = refModel(32'h7FFFFFFF, 32'd1, 1'b0);
        startOp(32'h7FFFFFFF, 32'd1, 1'b0);
        waitDone("bp");
        for (int i = 0; i < 10; i++) begin
            checkResult($sformatf("bp_hold%0d", i), e);
            checkOutput($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_a      = 32'd10;
        op_b      = 32'd20;
        sub       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_idle_after_pop", 32'(busy), 32'd0);
        checkOutput("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_next_accepted", 32'(busy), 32'd1);
        waitDone("bp_next");
        checkResult("bp_next", refModel(32'd10, 32'd20, 1'b0));
        popResult("bp_next");

        // Abort while DONE: no delivery, output registers keep the old result.
        e = refModel(32'd9, 32'd4, 1'b0);
        startOp(32'd9, 32'd4, 1'b0);
        waitDone("abort_done");
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_done_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_done_idle", 32'(in_ready), 32'd1);
        checkOutput("abort_done_result_held", result, e.r);

        // Abort at RUN bit 12: out_valid never rises, result is not updated.
        startOp(32'd100, 32'd200, 1'b0);
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            sawValid = sawValid | out_valid;
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_run_idle", 32'(in_ready), 32'd1);
        for (int i = 0; i < WIDTH; i++) begin
            sawValid = sawValid | out_valid;
            @(negedge clk);
        end
        checkOutput("abort_run_no_valid", 32'(sawValid), 32'd0);
        checkOutput("abort_run_result_held", result, e.r);
        applyStimulus("after_abort", 32'd1, 32'd1, 1'b0, '{32'd2, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset at RUN bit 20.
        startOp(32'hDEADBEEF, 32'h01234567, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_result", result, 32'd0);
        checkOutput("async_rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus("after_reset", 32'h12345678, 32'h11111111, 1'b0,
                      '{32'h23456789, 1'b0, 1'b0, 1'b0});

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 6 == 0) ? ra : $urandom;
            rs = $urandom_range(0, 1);
            applyStimulus($sformatf("rand%0d", i), ra, rb, rs, refModel(ra, rb, rs));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
